// File: rtl/int_ctrl.sv
// int_ctrl: interrupt entry (PUSH, VECTOR) and return (RTI) sequencer.
// Define INT_NEST_EN for a 3-bit nesting depth in place of the single mask bit.
module int_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       intr,
   input  logic       stall,
   input  logic       instr_valid,
   input  logic [3:0] op_code,
   input  logic [1:0] ra,
   output logic       sf1,
   output logic       sf2,
   output logic       int_push,
   output logic       flags_save,
   output logic       flags_restore,
   output logic       vec_load,
   output logic       flush,
   output logic       int_ack,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PUSH   = 2'd1,
      VECTOR = 2'd2
   } state_t;

   state_t state;
   logic   intr_q;
   logic   pending;
   logic   edge_det;
   logic   blocked;
   logic   accept;
   logic   rti;

   assign edge_det = intr & ~intr_q;
   assign accept   = (state == IDLE) & pending & ~blocked & ~stall;
   // an RTI that collides with an accept is flushed, so it is not taken
   assign rti      = (state == IDLE) & instr_valid
                   & (op_code == 4'b1011) & (ra == 2'b11)
                   & ~stall & ~accept;

`ifdef INT_NEST_EN
   logic [2:0] depth;

   assign blocked = (depth == 3'd7);

   // nesting depth: up on accept, down on return, floor at zero
   always_ff @(posedge clk) begin
      if (rst)
         depth <= 3'd0;
      else if (accept)
         depth <= depth + 3'd1;
      else if (rti && (depth != 3'd0))
         depth <= depth - 3'd1;
   end
`else
   logic mask;

   assign blocked = mask;

   // single-level mask: set on accept, cleared on return
   always_ff @(posedge clk) begin
      if (rst)
         mask <= 1'b0;
      else if (accept)
         mask <= 1'b1;
      else if (rti)
         mask <= 1'b0;
   end
`endif

   // edge detector and pending latch; a new edge beats a same-cycle accept
   always_ff @(posedge clk) begin
      if (rst) begin
         intr_q  <= 1'b0;
         pending <= 1'b0;
      end else if (!stall) begin
         intr_q <= intr;
         if (edge_det)
            pending <= 1'b1;
         else if (accept)
            pending <= 1'b0;
      end
   end

   // sequencer; outputs are registered from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sf1           <= 1'b0;
         sf2           <= 1'b0;
         int_push      <= 1'b0;
         flags_save    <= 1'b0;
         flags_restore <= 1'b0;
         vec_load      <= 1'b0;
         flush         <= 1'b0;
         int_ack       <= 1'b0;
         busy          <= 1'b0;
      end else if (!stall) begin
         flags_restore <= rti;
         unique case (state)
            IDLE: begin
               if (accept)
                  state <= PUSH;
               sf1        <= accept;
               int_push   <= accept;
               flags_save <= accept;
               flush      <= accept;
               busy       <= accept;
               sf2        <= 1'b0;
               vec_load   <= 1'b0;
               int_ack    <= 1'b0;
            end
            PUSH: begin
               state      <= VECTOR;
               sf1        <= 1'b0;
               int_push   <= 1'b0;
               flags_save <= 1'b0;
               sf2        <= 1'b1;
               vec_load   <= 1'b1;
               flush      <= 1'b1;
               int_ack    <= 1'b1;
               busy       <= 1'b1;
            end
            VECTOR: begin
               state      <= IDLE;
               sf1        <= 1'b0;
               int_push   <= 1'b0;
               flags_save <= 1'b0;
               sf2        <= 1'b0;
               vec_load   <= 1'b0;
               flush      <= 1'b0;
               int_ack    <= 1'b0;
               busy       <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               sf1        <= 1'b0;
               int_push   <= 1'b0;
               flags_save <= 1'b0;
               sf2        <= 1'b0;
               vec_load   <= 1'b0;
               flush      <= 1'b0;
               int_ack    <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus random traffic for int_ctrl,
// checked against a sequence-level reference model.
module tb_int_ctrl;

`ifdef INT_NEST_EN
   localparam int LIMIT = 7;
`else
   localparam int LIMIT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       intr = 1'b0;
   logic       stall = 1'b0;
   logic       instr_valid = 1'b0;
   logic [3:0] op_code = 4'd0;
   logic [1:0] ra = 2'd0;
   logic       sf1, sf2, int_push, flags_save, flags_restore;
   logic       vec_load, flush, int_ack, busy;
   logic [8:0] outs;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: phase 0 idle, 1 saving context, 2 vectoring
   int m_phase = 0;
   bit m_pend = 0;
   bit m_prev = 0;
   bit m_restore = 0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   int_ctrl dut (
      .clk(clk),
      .rst(rst),
      .intr(intr),
      .stall(stall),
      .instr_valid(instr_valid),
      .op_code(op_code),
      .ra(ra),
      .sf1(sf1),
      .sf2(sf2),
      .int_push(int_push),
      .flags_save(flags_save),
      .flags_restore(flags_restore),
      .vec_load(vec_load),
      .flush(flush),
      .int_ack(int_ack),
      .busy(busy)
   );

   assign outs = {sf1, sf2, int_push, flags_save, flags_restore,
                  vec_load, flush, int_ack, busy};

   task automatic model_step();
      bit rise, take, ret;
      if (rst) begin
         m_phase = 0;
         m_pend = 0;
         m_prev = 0;
         m_restore = 0;
         m_cnt = 0;
      end else if (!stall) begin
         rise = intr && !m_prev;
         take = (m_phase == 0) && m_pend && (m_cnt < LIMIT);
         ret = (m_phase == 0) && !take && instr_valid
               && (op_code == 4'b1011) && (ra == 2'b11);
         m_restore = ret;
         m_prev = intr;
         if (rise) m_pend = 1;
         else if (take) m_pend = 0;
         if (take) m_cnt++;
         else if (ret && m_cnt > 0) m_cnt--;
         if (take) m_phase = 1;
         else if (m_phase == 1) m_phase = 2;
         else m_phase = 0;
      end
   endtask

   function automatic logic [8:0] exp_outs();
      logic [8:0] v;
      v = 9'b0;
      if (m_phase == 1) v = 9'b101100101;
      if (m_phase == 2) v = 9'b010001111;
      v[4] = m_restore;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      intr = 1'b0;
      stall = 1'b0;
      instr_valid = 1'b0;
      op_code = 4'd0;
      ra = 2'd0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      stall = 1'b1;
      intr = 1'b0;
      instr_valid = 1'b0;
      tick();
      checks++;
      if (outs !== 9'b0) begin
         errors++;
         $display("FAIL reset_outs cyc=%0d got=%b exp=%b", cyc, outs, 9'b0);
      end
      rst = 1'b0;
      stall = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
      end
   endtask

   // rst in cycle 1, intr rises in cycle 3
   task automatic test_latency();
      rst = 1'b1;
      intr = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      intr = 1'b1;
      for (int c = 4; c <= 9; c++) begin
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL latency_model cyc=%0d got=%b exp=%b", c, outs, exp_outs());
         end
         if (c == 5) begin
            checks++;
            if (sf1 !== 1'b1) begin
               errors++;
               $display("FAIL latency_sf1 cyc=%0d got=%b exp=1", c, sf1);
            end
         end
         if (c == 6) begin
            checks++;
            if (int_ack !== 1'b1) begin
               errors++;
               $display("FAIL latency_ack cyc=%0d got=%b exp=1", c, int_ack);
            end
         end
         if (c == 7) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL latency_busy cyc=%0d got=%b exp=0", c, busy);
            end
         end
      end
      intr = 1'b0;
   endtask

   // second pulse lands in PUSH; RTI issued later
   task automatic test_nest_hold();
      logic [19:0] intr_pat;
      logic [19:0] rti_pat;
      int acks, restore_at, sf1_after;
      bit prev_ack;
      intr_pat = 20'b0000_0000_0000_0000_0101;
      rti_pat  = 20'b0000_0000_0100_0000_0000;
      acks = 0;
      restore_at = -1;
      sf1_after = -1;
      prev_ack = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         intr = intr_pat[i];
         instr_valid = rti_pat[i];
         op_code = rti_pat[i] ? 4'b1011 : 4'b0110;
         ra = rti_pat[i] ? 2'b11 : 2'b01;
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL nest_hold_model cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
         if (i < 10 && int_ack && !prev_ack) acks++;
         prev_ack = int_ack;
         if (flags_restore && restore_at < 0) restore_at = i;
         if (restore_at >= 0 && sf1 && sf1_after < 0) sf1_after = i;
      end
      instr_valid = 1'b0;
      checks++;
      if (acks !== ((LIMIT > 1) ? 2 : 1)) begin
         errors++;
         $display("FAIL nest_hold_acks got=%0d exp=%0d", acks, (LIMIT > 1) ? 2 : 1);
      end
`ifndef INT_NEST_EN
      checks++;
      if (sf1_after - restore_at !== 1) begin
         errors++;
         $display("FAIL nest_hold_resume got=%0d exp=1", sf1_after - restore_at);
      end
`endif
   endtask

   task automatic test_stall();
      int sf1_cnt, acks;
      bit prev_ack;
      sf1_cnt = 0;
      acks = 0;
      prev_ack = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         intr = (i == 0);
         stall = (i >= 2 && i <= 4);
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL stall_model cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
         if (sf1) sf1_cnt++;
         if (int_ack && !prev_ack) acks++;
         prev_ack = int_ack;
      end
      stall = 1'b0;
      checks++;
      if (sf1_cnt !== 4) begin
         errors++;
         $display("FAIL stall_sf1_len got=%0d exp=4", sf1_cnt);
      end
      checks++;
      if (acks !== 1) begin
         errors++;
         $display("FAIL stall_acks got=%0d exp=1", acks);
      end
   endtask

   task automatic test_reset_mid();
      int busy_cnt;
      busy_cnt = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         intr = (i == 0) || (i == 2);
         rst = (i == 3);
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL reset_mid_model cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
         if (i == 3) begin
            checks++;
            if (outs !== 9'b0) begin
               errors++;
               $display("FAIL reset_mid_outs cyc=%0d got=%b exp=%b", cyc, outs, 9'b0);
            end
         end
         if (i > 3 && busy) busy_cnt++;
      end
      rst = 1'b0;
      intr = 1'b0;
      checks++;
      if (busy_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_restart got=%0d exp=0", busy_cnt);
      end
   endtask

   task automatic test_depth();
      int acks;
      bit prev_ack;
      acks = 0;
      prev_ack = 0;
      do_reset();
      for (int p = 0; p <= LIMIT; p++) begin
         for (int i = 0; i < 7; i++) begin
            intr = (i == 0);
            tick();
            checks++;
            if (outs !== exp_outs()) begin
               errors++;
               $display("FAIL depth_model cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
            end
            if (int_ack && !prev_ack) acks++;
            prev_ack = int_ack;
         end
      end
      checks++;
      if (acks !== LIMIT) begin
         errors++;
         $display("FAIL depth_blocked got=%0d exp=%0d", acks, LIMIT);
      end
      for (int i = 0; i < 8; i++) begin
         instr_valid = (i == 0);
         op_code = 4'b1011;
         ra = 2'b11;
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL depth_rti_model cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
         if (int_ack && !prev_ack) acks++;
         prev_ack = int_ack;
      end
      instr_valid = 1'b0;
      checks++;
      if (acks !== LIMIT + 1) begin
         errors++;
         $display("FAIL depth_release got=%0d exp=%0d", acks, LIMIT + 1);
      end
   endtask

   // RTI decoded in the accept cycle must be dropped
   task automatic test_rti_collision();
      int acks;
      bit prev_ack;
      acks = 0;
      prev_ack = 0;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         intr = (i == 0) || (i == 6);
         instr_valid = (i == 1) || (i == 2);
         op_code = 4'b1011;
         ra = 2'b11;
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL collide_model cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
         if (i == 1) begin
            checks++;
            if ({sf1, flags_restore} !== 2'b10) begin
               errors++;
               $display("FAIL collide_win cyc=%0d got=%b exp=10", cyc, {sf1, flags_restore});
            end
         end
         if (int_ack && !prev_ack) acks++;
         prev_ack = int_ack;
      end
      instr_valid = 1'b0;
      checks++;
      if (acks !== ((LIMIT > 1) ? 2 : 1)) begin
         errors++;
         $display("FAIL collide_acks got=%0d exp=%0d", acks, (LIMIT > 1) ? 2 : 1);
      end
   endtask

   task automatic test_level();
      int acks;
      bit prev_ack;
      acks = 0;
      prev_ack = 0;
      do_reset();
      for (int i = 0; i < 26; i++) begin
         intr = (i < 20);
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL level_model cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
         if (int_ack && !prev_ack) acks++;
         prev_ack = int_ack;
      end
      checks++;
      if (acks !== 1) begin
         errors++;
         $display("FAIL level_acks got=%0d exp=1", acks);
      end
   endtask

   // stall only while intr matches its registered copy and holds steady
   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         stall = ($urandom_range(0, 6) == 0) && (intr == m_prev);
         if (!stall && $urandom_range(0, 4) == 0)
            intr = ~intr;
         instr_valid = ($urandom_range(0, 3) != 0);
         op_code = ($urandom_range(0, 1) == 0) ? 4'b1011 : 4'($urandom);
         ra = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom);
         tick();
         checks++;
         if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, outs, exp_outs());
         end
      end
      rst = 1'b0;
      stall = 1'b0;
      intr = 1'b0;
      instr_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_nest_hold();
      test_stall();
      test_reset_mid();
      test_depth();
      test_rti_collision();
      test_level();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 intr  in  1  external interrupt request, level input, synchronous to clk.
REQ-004 stall  in  1  pipeline hold; 1 freezes FSM, pending, mask/depth and all outputs.
REQ-005 instr_valid  in  1  decode slot holds a valid instruction.
REQ-006 op_code  in  4  decode-slot opcode.
REQ-007 ra  in  2  decode-slot ra field.
REQ-008 sf1  out  1  registered interrupt flag to ALU control: SP pass-through cycle.
REQ-009 sf2  out  1  registered flag: vector-fetch cycle.
REQ-010 int_push  out  1  write PC to M[SP], decrement SP.
REQ-011 flags_save  out  1  copy CCR to shadow CCR.
REQ-012 flags_restore  out  1  copy shadow CCR to CCR.
REQ-013 vec_load  out  1  PC <= M[1].
REQ-014 flush  out  1  bubble IF/ID.
REQ-015 int_ack  out  1  one-cycle acknowledge to requester.
REQ-016 busy  out  1  sequence in progress.

Function
REQ-017 Rising edge detect SHALL use registered intr_q: edge = intr & ~intr_q.
REQ-018 pending SHALL set on edge and clear on the accept cycle; simultaneous set and clear SHALL leave pending = 1.
REQ-019 States SHALL be IDLE, PUSH, VECTOR; all outputs are decoded from registered state only (no input-to-output combinational path).
REQ-020 IDLE->PUSH SHALL occur when pending & ~mask & ~stall; that cycle is the accept cycle.
REQ-021 PUSH SHALL assert sf1, int_push, flags_save, flush, busy, and advance to VECTOR unless stall.
REQ-022 VECTOR SHALL assert sf2, vec_load, flush, int_ack, busy, and return to IDLE unless stall.
REQ-023 Latency: accept at cycle N gives sf1 at N+1, int_ack at N+2, IDLE at N+3 (no stall).
REQ-024 RTI is instr_valid & op_code==4'b1011 & ra==2'b11 & ~stall in IDLE; it SHALL pulse flags_restore for one cycle on the next cycle and release mask/depth.
REQ-025 RTI and accept in the same IDLE cycle: accept SHALL win; the RTI is ignored because the instruction is flushed.
REQ-026 RTI decode in PUSH/VECTOR SHALL be ignored.
REQ-027 Edges during PUSH/VECTOR SHALL set pending and be serviced after return to IDLE, subject to mask/depth.
REQ-028 Stall in PUSH/VECTOR SHALL extend that state; asserted outputs stay asserted, with no duplicate side-effect counted by the bench beyond held levels.

Reset
REQ-029 On rst: state=IDLE; intr_q, pending, mask, depth=0; all outputs 0 on the following cycle.
REQ-030 Reset mid-sequence SHALL abort to IDLE and discard pending; rst has priority over stall.

Configuration
REQ-031 Macro INT_NEST_EN.
- Without it: 1-bit mask set on accept, cleared on RTI; while mask = 1, pending is held and not accepted.
- With it: no mask; a 3-bit depth counter increments on accept and decrements on RTI (floor 0). At depth 7, accept is blocked and pending is held.

Verification
REQ-032 rst 1 cycle; intr 0->1 at cycle 3 -> sf1=1 at cycle 5, int_ack=1 at cycle 6, busy low at cycle 7.
REQ-033 intr pulse, then a second pulse during PUSH (no INT_NEST_EN) -> first serviced; second held pending; after RTI (op 1011, ra 11), second sequence starts 1 cycle after the flags_restore pulse.
REQ-034 stall=1 for 3 cycles in PUSH -> sf1 held 4 cycles total; VECTOR follows; exactly one int_ack pulse.
REQ-035 rst asserted during VECTOR with another request pending -> all outputs 0 next cycle; no further sequence without a new edge.
REQ-036 INT_NEST_EN: 8 edges with no RTI -> 7 sequences complete; 8th blocked until one RTI, then serviced.
REQ-037 intr held high 20 cycles -> exactly one sequence (edge-triggered).
